// File: rtl/micro_op_queue_pkg.sv
// Shared field widths, opcode constants and the micro-op record for the decode-side queue.
// The width macros normally arrive from common_params.h; the fallbacks below match it.
`ifndef MICRO_W
`define MICRO_W 7
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef IMM_W
`define IMM_W 32
`endif
`ifndef BIT_MODE_W
`define BIT_MODE_W 2
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef MICRO_NOP
`define MICRO_NOP 0
`endif
`ifndef MICRO_ADDI
`define MICRO_ADDI 12
`endif

package micro_op_queue_pkg;

    localparam int MICRO_W    = `MICRO_W;
    localparam int REG_ADDR_W = `REG_ADDR_W;
    localparam int IMM_W      = `IMM_W;
    localparam int BIT_MODE_W = `BIT_MODE_W;
    localparam int ADDR_W     = `ADDR_W;

    localparam logic [MICRO_W-1:0] MICRO_NOP  = MICRO_W'(`MICRO_NOP);
    localparam logic [MICRO_W-1:0] MICRO_ADDI = MICRO_W'(`MICRO_ADDI);

    typedef struct packed {
        logic [MICRO_W-1:0]    opcode;
        logic [REG_ADDR_W-1:0] addr_d;
        logic [REG_ADDR_W-1:0] addr_s;
        logic [REG_ADDR_W-1:0] addr_t;
        logic [IMM_W-1:0]      immediate;
        logic [BIT_MODE_W-1:0] bit_mode;
        logic                  efl_mode;
        logic [ADDR_W-1:0]     pc;
    } uop_t;

endpackage

// File: rtl/micro_op_queue.sv
// Strict-FIFO micro-op queue between decode stages; head fields read combinationally
// from the rd_ptr entry and forced to zero (a NOP) whenever the queue is empty.
module micro_op_queue
    import micro_op_queue_pkg::*;
#(
    parameter int DEPTH = 8
)
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enq_valid,
    input  logic [MICRO_W-1:0]      enq_opcode,
    input  logic [REG_ADDR_W-1:0]   enq_reg_addr_d,
    input  logic [REG_ADDR_W-1:0]   enq_reg_addr_s,
    input  logic [REG_ADDR_W-1:0]   enq_reg_addr_t,
    input  logic [IMM_W-1:0]        enq_immediate,
    input  logic [BIT_MODE_W-1:0]   enq_bit_mode,
    input  logic                    enq_efl_mode,
    input  logic [ADDR_W-1:0]       enq_pc,
    output logic                    enq_ready,
    output logic [MICRO_W-1:0]      deq_opcode_head,
    output logic [REG_ADDR_W-1:0]   deq_reg_addr_d_head,
    output logic [REG_ADDR_W-1:0]   deq_reg_addr_s_head,
    output logic [REG_ADDR_W-1:0]   deq_reg_addr_t_head,
    output logic [IMM_W-1:0]        deq_immediate_head,
    output logic [BIT_MODE_W-1:0]   deq_bit_mode_head,
    output logic                    deq_efl_mode_head,
    output logic [ADDR_W-1:0]       deq_pc_head,
    output logic                    deq_valid,
    input  logic                    stall,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [MICRO_W-1:0]    r_opcode    [DEPTH];
    logic [REG_ADDR_W-1:0] r_addr_d    [DEPTH];
    logic [REG_ADDR_W-1:0] r_addr_s    [DEPTH];
    logic [REG_ADDR_W-1:0] r_addr_t    [DEPTH];
    logic [IMM_W-1:0]      r_immediate [DEPTH];
    logic [BIT_MODE_W-1:0] r_bit_mode  [DEPTH];
    logic                  r_efl_mode  [DEPTH];
    logic [ADDR_W-1:0]     r_pc        [DEPTH];

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;
    uop_t w_head;

    // Readiness looks only at occupancy, so a full queue never accepts even while popping.
    assign enq_ready = (r_count != FULL_CNT);
    assign deq_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = enq_valid & enq_ready & ~flush;
    assign w_pop  = deq_valid & ~stall & ~flush;

    // Storage holds no reset; empty-queue masking on the head covers stale contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_opcode[r_wr_ptr]    <= enq_opcode;
            r_addr_d[r_wr_ptr]    <= enq_reg_addr_d;
            r_addr_s[r_wr_ptr]    <= enq_reg_addr_s;
            r_addr_t[r_wr_ptr]    <= enq_reg_addr_t;
            r_immediate[r_wr_ptr] <= enq_immediate;
            r_bit_mode[r_wr_ptr]  <= enq_bit_mode;
            r_efl_mode[r_wr_ptr]  <= enq_efl_mode;
            r_pc[r_wr_ptr]        <= enq_pc;
        end
    end

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_head        = '0;
        w_head.opcode = MICRO_NOP;
        if (deq_valid) begin
            w_head.opcode    = r_opcode[r_rd_ptr];
            w_head.addr_d    = r_addr_d[r_rd_ptr];
            w_head.addr_s    = r_addr_s[r_rd_ptr];
            w_head.addr_t    = r_addr_t[r_rd_ptr];
            w_head.immediate = r_immediate[r_rd_ptr];
            w_head.bit_mode  = r_bit_mode[r_rd_ptr];
            w_head.efl_mode  = r_efl_mode[r_rd_ptr];
            w_head.pc        = r_pc[r_rd_ptr];
        end
    end

    assign deq_opcode_head     = w_head.opcode;
    assign deq_reg_addr_d_head = w_head.addr_d;
    assign deq_reg_addr_s_head = w_head.addr_s;
    assign deq_reg_addr_t_head = w_head.addr_t;
    assign deq_immediate_head  = w_head.immediate;
    assign deq_bit_mode_head   = w_head.bit_mode;
    assign deq_efl_mode_head   = w_head.efl_mode;
    assign deq_pc_head         = w_head.pc;

endmodule

// File: doc/micro_op_queue.md
MICRO_OP_QUEUE -- requirements
Module: micro_op_queue

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter DEPTH, default 8, the number of entries; it is a power of two and at least 2.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- enq_valid  in  1  producer offers one micro-op this cycle
- enq_opcode  in  `MICRO_W  micro-op opcode
- enq_reg_addr_d / enq_reg_addr_s / enq_reg_addr_t  in  `REG_ADDR_W each  register addresses
- enq_immediate  in  `IMM_W  immediate
- enq_bit_mode  in  `BIT_MODE_W  operand size
- enq_efl_mode  in  1  flag-update enable
- enq_pc  in  `ADDR_W  instruction address
- enq_ready  out  1  queue can accept an entry
- deq_opcode_head, deq_reg_addr_d_head, deq_reg_addr_s_head, deq_reg_addr_t_head, deq_immediate_head, deq_bit_mode_head, deq_efl_mode_head, deq_pc_head  out  widths as the matching enq_*  head entry fields
- deq_valid  out  1  head entry holds a real micro-op
- stall  in  1  decode is not consuming this cycle
- flush  in  1  discard all entries
- count  out  $clog2(DEPTH)+1  current occupancy

Function
REQ-004 A push SHALL occur when enq_valid & enq_ready & ~flush; the entry is written at wr_ptr and wr_ptr advances by 1 modulo DEPTH.
REQ-005 A pop SHALL occur when deq_valid & ~stall & ~flush; rd_ptr advances by 1 modulo DEPTH.
REQ-006 enq_ready SHALL be combinational and equal (count != DEPTH); there is no pass-through while full, even when a pop happens in the same cycle.
REQ-007 deq_valid SHALL equal (count != 0).
REQ-008 The head outputs SHALL be combinational from the entry at rd_ptr when deq_valid=1; when deq_valid=0 every head output SHALL be 0, so the downstream stage latches `MICRO_NOP.
REQ-009 Enqueue-to-head latency SHALL be 1 cycle; there is no bypass from enq_* to the head outputs.
REQ-010 count SHALL update as follows: +1 on push only, -1 on pop only, unchanged when a push and a pop happen in the same cycle.
REQ-011 A push and a pop in the same cycle SHALL both be legal at any occupancy from 1 to DEPTH-1.
REQ-012 When count==DEPTH and a pop occurs, the next cycle SHALL have count DEPTH-1 and enq_ready=1.
REQ-013 Both pointers SHALL wrap from DEPTH-1 to 0 without losing or reordering entries; the queue is strict FIFO.
REQ-014 flush SHALL have priority over push and pop; the next cycle has rd_ptr=wr_ptr=0, count=0 and deq_valid=0, and any enq_valid in the flush cycle is dropped.
REQ-015 stall=1 SHALL hold the queue contents and the head outputs unchanged, except for a push.
REQ-016 enq_valid while enq_ready=0 SHALL have no effect; the producer holds its data and retries.

Reset
REQ-017 On rstn=0, asynchronously: rd_ptr=0, wr_ptr=0, count=0, deq_valid=0, every head output 0, enq_ready=1.
REQ-018 Storage array contents SHALL NOT require reset; REQ-008 masks them.
REQ-019 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion becomes the head one cycle later.

Structure
REQ-020 The field widths `MICRO_W, `REG_ADDR_W, `IMM_W, `BIT_MODE_W and `ADDR_W, and `MICRO_NOP (value 0), SHALL come from common_params.h; no new widths are defined locally.
REQ-021 The block SHALL be a single module with no sub-module; the storage is one array per field, indexed by rd_ptr/wr_ptr.

Verification
REQ-022 Push A (opcode `MICRO_ADDI, pc 0x100) into an empty queue with stall=0 -> the next cycle shows the head = A and deq_valid=1; one cycle later deq_valid=0 and the head is all 0.
REQ-023 With stall=1, push 8 entries at pc 0x0..0x7 -> count=8, enq_ready=0, a 9th push is ignored; release stall -> pc 0x0..0x7 appear in order, one per cycle.
REQ-024 Hold occupancy at 3 with simultaneous push/pop for 20 cycles -> count stays 3, the order is preserved and both pointers wrap at least twice.
REQ-025 Occupancy 5, assert flush together with enq_valid=1 -> the next cycle has count=0 and deq_valid=0, and the pushed entry never appears.
REQ-026 Assert rstn=0 asynchronously between clock edges at occupancy 4 -> deq_valid and count drop to 0 immediately without waiting for clk; after release, push B -> B is the head one cycle later.
REQ-027 Full queue, stall=0, enq_valid=1 -> no push in that cycle; the next cycle has count=7 and enq_ready=1, and the push then succeeds.
